// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - 32-bit MEM-stage port onto a 16-bit async SRAM, two halfword phases per word.
// Optional build macro SRAM_CTRL_ERR_EN adds the err output and a misaligned/below-base address check.
module sram_ctrl #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrEn,
    input  logic        rdEn,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic        freeze,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
`ifdef SRAM_CTRL_ERR_EN
    ,
    output logic        err
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LO   = 2'd1;
    localparam logic [1:0] S_HI   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;
    localparam logic [2:0] CNT_LAST = 3'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [16:0] hw_q, hw_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        we_n_q, we_n_d;
    logic        err_q, err_d;
    logic        bad_addr;
    logic        drive_dq;

`ifdef SRAM_CTRL_ERR_EN
    assign bad_addr = (address < 32'(BASE_ADDR)) || (address[1:0] != 2'b00);
`else
    assign bad_addr = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        hw_d    = hw_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (wrEn || rdEn) begin
                    wr_d    = wrEn;
                    hw_d    = 17'((address - 32'(BASE_ADDR)) >> 2);
                    wdata_d = writeData;
                    cnt_d   = 3'd0;
                    err_d   = bad_addr;
                    state_d = bad_addr ? S_DONE : S_LO;
                end
            end
            S_LO: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = S_HI;
                    if (!wr_q) rdata_d[15:0] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_HI: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = 3'd0;
                    state_d = S_DONE;
                    if (!wr_q) rdata_d[31:16] = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Strobe is registered from next state so it aligns exactly with the LO/HI phases.
        we_n_d = !(wr_d && (state_d == S_LO || state_d == S_HI));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            wr_q    <= 1'b0;
            hw_q    <= 17'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            we_n_q  <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            hw_q    <= hw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_n_q  <= we_n_d;
            err_q   <= err_d;
        end
    end

    assign ready     = (state_q == S_DONE);
    assign freeze    = (wrEn || rdEn) && !ready;
    assign readData  = rdata_q;
    assign SRAM_WE_N = we_n_q;
    assign drive_dq  = wr_q && (state_q == S_LO || state_q == S_HI);
    assign SRAM_DQ   = drive_dq ? ((state_q == S_HI) ? wdata_q[31:16] : wdata_q[15:0]) : 16'hzzzz;

    always_comb begin
        SRAM_ADDR = 18'd0;
        if (state_q == S_LO) SRAM_ADDR = {hw_q, 1'b0};
        if (state_q == S_HI) SRAM_ADDR = {hw_q, 1'b1};
    end

    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

`ifdef SRAM_CTRL_ERR_EN
    assign err = err_q && (state_q == S_DONE);
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - scoreboard bench for sram_ctrl with a behavioural SRAM on SRAM_DQ.
module tb_sram_ctrl;

    localparam int W   = 2;
    localparam int LAT = 2 * W + 1;

    logic        clk = 1'b0;
    logic        rst, wrEn, rdEn;
    logic [31:0] address, writeData;
    logic [31:0] readData;
    logic        ready, freeze;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
`ifdef SRAM_CTRL_ERR_EN
    logic        err;
`endif

    logic [15:0] mem     [0:1023];
    logic [15:0] ref_mem [0:1023];
    logic        tb_rd_active;
    logic [31:0] last_rd;
    logic [31:0] exp_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;

    always #5 clk = ~clk;

    sram_ctrl #(.BASE_ADDR(1024), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .wrEn(wrEn), .rdEn(rdEn),
        .address(address), .writeData(writeData),
        .readData(readData), .ready(ready), .freeze(freeze),
        .SRAM_DQ(SRAM_DQ), .SRAM_ADDR(SRAM_ADDR),
        .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
        .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
        .SRAM_WE_N(SRAM_WE_N)
`ifdef SRAM_CTRL_ERR_EN
        , .err(err)
`endif
    );

    assign SRAM_DQ = tb_rd_active ? mem[SRAM_ADDR[9:0]] : 16'hzzzz;

    always @(posedge clk)
        if (SRAM_WE_N === 1'b0) mem[SRAM_ADDR[9:0]] <= SRAM_DQ;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the request is first seen at the next rising edge (cycle 0).
    task automatic access(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d,
                          input int drop_at, input int chg_at, input string tag);
        int lat, we_low, frz, h;
        h = int'((((a - 32'd1024) >> 2) << 1) & 32'd1022);
        wrEn = wr; rdEn = rd; address = a; writeData = d;
        tb_rd_active = rd & ~wr;
        if (wr) begin
            ref_mem[h]     = d[15:0];
            ref_mem[h + 1] = d[31:16];
        end else begin
            last_rd = {ref_mem[h + 1], ref_mem[h]};
        end
        exp_q.push_back(last_rd);
        lat = -1; we_low = 0; frz = 0;
        for (int c = 0; c < 4 * LAT; c++) begin
            #1;
            if (freeze) frz++;
            if (ready) begin lat = c; break; end
            if (SRAM_WE_N === 1'b0) we_low++;
            if (c == drop_at) begin wrEn = 1'b0; rdEn = 1'b0; end
            if (c == chg_at) begin address = ~a; writeData = ~d; end
            @(negedge clk);
        end
        chk({tag, "_lat"}, lat, LAT);
        chk({tag, "_we_low"}, we_low, wr ? 2 * W : 0);
        if (drop_at < 0) chk({tag, "_freeze"}, frz, LAT);
        chk({tag, "_rdata"}, readData, exp_q.pop_front());
        wrEn = 1'b0; rdEn = 1'b0; tb_rd_active = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pulses, p0, p1;
        for (int i = 0; i < 1024; i++) begin mem[i] = 16'h0; ref_mem[i] = 16'h0; end
        rst = 1'b0; wrEn = 1'b0; rdEn = 1'b1; address = 32'd1024; writeData = 32'd0;
        tb_rd_active = 1'b0; last_rd = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdata", readData, 32'd0);
        chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
        chk("rst_dq_z", {31'd0, SRAM_DQ === 16'hzzzz}, 32'd1);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_freeze", {31'd0, freeze}, 32'd1);
        chk("ties", {28'd0, SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N}, 32'd0);
        rdEn = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, -1, -1, "wr0");
        chk("wr0_mem0", {16'd0, mem[0]}, 32'h0000BEEF);
        chk("wr0_mem1", {16'd0, mem[1]}, 32'h0000DEAD);
        access(1'b0, 1'b1, 32'd1024, 32'd0, -1, -1, "rd0");
        chk("rd0_const", readData, 32'hDEADBEEF);

        access(1'b1, 1'b1, 32'd1028, 32'h12345678, -1, -1, "both");
        chk("both_mem2", {16'd0, mem[2]}, 32'h00005678);
        chk("both_mem3", {16'd0, mem[3]}, 32'h00001234);
        chk("both_rdata", readData, 32'hDEADBEEF);

        access(1'b0, 1'b1, 32'd1028, 32'd0, 1, -1, "drop");
        access(1'b1, 1'b0, 32'd1036, 32'hA5A55A5A, -1, 1, "chg");
        access(1'b0, 1'b1, 32'd1036, 32'd0, -1, -1, "chg_rd");

        // Back-to-back reads with rdEn held for 12 cycles.
        rdEn = 1'b1; address = 32'd1024; tb_rd_active = 1'b1;
        last_rd = {ref_mem[1], ref_mem[0]};
        exp_q.push_back(last_rd);
        exp_q.push_back(last_rd);
        pulses = 0; p0 = -1; p1 = -1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (ready) begin
                if (pulses == 0) p0 = c; else p1 = c;
                pulses++;
                chk("b2b_rdata", readData, exp_q.pop_front());
            end
            @(negedge clk);
        end
        rdEn = 1'b0; tb_rd_active = 1'b0;
        chk("b2b_pulses", pulses, 2);
        chk("b2b_p0", p0, 5);
        chk("b2b_p1", p1, 11);
        @(negedge clk);

        // Reset during the HI phase of a write.
        wrEn = 1'b1; address = 32'd1032; writeData = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_hi_we", {31'd0, SRAM_WE_N}, 32'd0);
        rst = 1'b0; wrEn = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_we_n", {31'd0, SRAM_WE_N}, 32'd1);
        chk("mid_dq_z", {31'd0, SRAM_DQ === 16'hzzzz}, 32'd1);
        chk("mid_ready", {31'd0, ready}, 32'd0);
        chk("mid_rdata", readData, 32'd0);
        rst = 1'b1;
        ref_mem[4] = 16'hF00D; ref_mem[5] = 16'hCAFE; last_rd = 32'd0;
        @(negedge clk);
        access(1'b0, 1'b1, 32'd1032, 32'd0, -1, -1, "partial");

        for (int i = 0; i < 10; i++) begin
            logic [31:0] ra;
            logic        rw;
            ra = 32'd1024 + 32'(4 * $urandom_range(0, 15));
            rw = 1'($urandom_range(0, 1));
            access(rw, ~rw, ra, $urandom, -1, -1, "rnd");
        end

`ifdef SRAM_CTRL_ERR_EN
        begin
            int lat, act;
            rdEn = 1'b1; address = 32'd1022; lat = -1; act = 0;
            for (int c = 0; c < 10; c++) begin
                #1;
                if (SRAM_WE_N !== 1'b1 || SRAM_ADDR !== 18'd0) act++;
                if (ready) begin
                    lat = c;
                    chk("err_flag", {31'd0, err}, 32'd1);
                    chk("err_rdata", readData, last_rd);
                    break;
                end
                @(negedge clk);
            end
            rdEn = 1'b0;
            chk("err_lat", lat, 1);
            chk("err_act", act, 0);
            @(negedge clk);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter: BASE_ADDR, 1024, byte address mapped to SRAM halfword 0.
REQ-002 Parameter: WAIT_CYCLES, 2, SRAM cycles held per halfword phase; legal range 1..7.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-low.
REQ-005 Port: wrEn  input  1  write request from MEM stage.
REQ-006 Port: rdEn  input  1  read request from MEM stage.
REQ-007 Port: address  input  32  byte address of 32-bit word.
REQ-008 Port: writeData  input  32  store data.
REQ-009 Port: readData  output  32  load data, registered.
REQ-010 Port: ready  output  1  one-cycle pulse, access complete.
REQ-011 Port: freeze  output  1  pipeline stall, combinational: (wrEn|rdEn) & ~ready.
REQ-012 Port: SRAM_DQ  inout  16  SRAM data bus.
REQ-013 Port: SRAM_ADDR  output  18  SRAM halfword address.
REQ-014 Port: SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N  output  1 each  tied 0.
REQ-015 Port: SRAM_WE_N  output  1  write strobe, active-low, registered.

Function
REQ-016 FSM states: IDLE, LO, HI, DONE; 3-bit wait counter cnt.
REQ-017 IDLE: wrEn|rdEn -> LO, cnt=0, latch op (write wins if both), latch address and writeData.
REQ-018 LO/HI: cnt increments each cycle; at cnt==WAIT_CYCLES-1 -> next state (LO->HI, HI->DONE), cnt=0.
REQ-019 DONE: ready=1 for exactly one cycle -> IDLE; no new request accepted in DONE cycle.
REQ-020 Mapping: off=address-BASE_ADDR; SRAM_ADDR={off[18:2], 1'b0} in LO, {off[18:2], 1'b1} in HI; address[1:0] ignored.
REQ-021 Write: LO drives writeData[15:0], HI drives writeData[31:16] on SRAM_DQ; SRAM_WE_N=0 throughout both phases.
REQ-022 Read: SRAM_DQ high-Z; SRAM_WE_N=1; DQ sampled on last cycle of LO into readData[15:0], of HI into readData[31:16].
REQ-023 SRAM_DQ high-Z in IDLE and DONE; SRAM_WE_N=1 outside write phases.
REQ-024 Latency: request first seen in cycle 0 -> ready in cycle 2*WAIT_CYCLES+1 (5 at default); freeze high cycles 0..2*WAIT_CYCLES.
REQ-025 Request deasserted mid-access: access completes unchanged; ready still pulses.
REQ-026 Request held after ready: new access starts the cycle after DONE (back-to-back).
REQ-027 readData holds last read value until next read overwrites; writes leave it unchanged.
REQ-028 Address/data changes after acceptance ignored (latched values used).

Reset
REQ-029 rst==0 at clock edge: state=IDLE, cnt=0, readData=0, SRAM_WE_N=1, SRAM_ADDR=0, DQ high-Z, ready=0.
REQ-030 Reset mid-access aborts; partial SRAM write not rolled back; readData cleared.

Configuration
REQ-031 Macro SRAM_CTRL_ERR_EN: adds output err (1 bit) and address check.
REQ-032 With SRAM_CTRL_ERR_EN: address<BASE_ADDR or address[1:0]!=0 -> IDLE->DONE directly, no SRAM cycles, WE_N stays 1, err=1 with ready pulse, readData unchanged.
REQ-033 Without SRAM_CTRL_ERR_EN: no err port; every request performs full access per REQ-020.

Verification
REQ-034 Write address=1024, writeData=0xDEADBEEF -> SRAM_ADDR 0 gets 0xBEEF, 1 gets 0xDEAD, WE_N low 4 cycles, ready at cycle 5.
REQ-035 Read address=1024 after REQ-034 -> readData=0xDEADBEEF at ready, freeze high cycles 0..4.
REQ-036 wrEn=rdEn=1, address=1028, data 0x12345678 -> write performed to halfwords 2,3; readData unchanged.
REQ-037 rst=0 during HI phase of a write -> next cycle IDLE, WE_N=1, DQ high-Z, ready=0.
REQ-038 rdEn held high 12 cycles -> two ready pulses at cycles 5 and 11.
REQ-039 With SRAM_CTRL_ERR_EN, read address=1022 -> err=1, ready at cycle 1, no SRAM_WE_N/SRAM_ADDR activity.
